div_controller: RTL and testbench
=================================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1: enables one-cycle resolution of special cases and last-result reuse.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles spent in WAIT before abort.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1: execute stage presents a divide op.
REQ-006 SHALL have port req_op  input  2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have ports req_a, req_b  input  32 each: dividend and divisor.
REQ-008 SHALL have port flush  input  1: kills the in-flight or presented op.
REQ-009 SHALL have port stall  output  1: pipeline hold request.
REQ-010 SHALL have port resp_valid  output  1: one-cycle result strobe.
REQ-011 SHALL have port resp_data  output  32: result.
REQ-012 SHALL have port resp_err  output  1: timeout indication, valid with resp_valid.
REQ-013 SHALL have port div_start  output  1: launch pulse to divider.
REQ-014 SHALL have port div_opcode  output  2: opcode to divider.
REQ-015 SHALL have ports div_op1, div_op2  output  32 each: operands to divider.
REQ-016 SHALL have port div_done  input  1: divider completion pulse.
REQ-017 SHALL have port div_result  input  32: divider result, valid with div_done.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-019 IDLE SHALL accept when req_valid=1 and flush=0, latching req_op/req_a/req_b.
REQ-020 On accept with BYPASS_EN=1, a special case SHALL go to RESP with a precomputed result, without touching the divider.
REQ-021 Special-case results SHALL be:
  - b==0: DIV/DIVU -> FFFFFFFF; REM/REMU -> a.
  - a=80000000, b=FFFFFFFF: DIV -> 80000000; REM -> 0.
REQ-022 On accept with BYPASS_EN=1, a last-result hit (valid entry; op, a, b all equal) SHALL go to RESP with the cached result.
REQ-023 Any other accepted op SHALL go to ISSUE.
REQ-024 ISSUE SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-025 div_opcode/div_op1/div_op2 SHALL be driven from latched values, stable from ISSUE until div_done is seen.
REQ-026 WAIT SHALL capture div_result on div_done, update the cache entry, and go to RESP.
REQ-027 WAIT SHALL count cycles; on reaching TIMEOUT without div_done it SHALL go to RESP with result 0, resp_err=1, and no cache update.
REQ-028 RESP SHALL hold one cycle and return to IDLE.
REQ-029 resp_valid SHALL equal (state==RESP && flush==0).
REQ-030 stall SHALL equal (IDLE && req_valid && !flush) || ISSUE || WAIT || (DRAIN && req_valid); stall SHALL be 0 in RESP.
REQ-031 Latency, accept at cycle N:
  - bypass or hit: resp_valid at N+1.
  - divider path, div_done at cycle D: resp_valid at D+1 (minimum N+3).
REQ-032 flush in ISSUE or WAIT SHALL go to DRAIN, where div_done is awaited, its result discarded with no cache update, then IDLE; DRAIN SHALL also exit to IDLE on TIMEOUT.
REQ-033 flush in ISSUE SHALL still issue the div_start pulse so the divider handshake completes.
REQ-034 div_done outside WAIT/DRAIN SHALL be ignored.
REQ-035 flush SHALL NOT invalidate the cache entry.

Reset
REQ-036 rst=0 SHALL force IDLE, clear the timeout counter, and invalidate the cache, asynchronously.
REQ-037 During reset, all outputs (stall, resp_valid, resp_data, resp_err, div_start, div_opcode, div_op1, div_op2) SHALL be 0.
REQ-038 Reset mid-operation SHALL abandon the op without a resp_valid pulse.

Verification
REQ-039 Bench SHALL cover DIV a=100 b=7, divider done 1 cycle after start -> div_start at N+1, resp_data=14 at N+3, stall high N..N+2.
REQ-040 Bench SHALL cover DIVU b=0 -> resp_data=FFFFFFFF at N+1, div_start never asserted; REM a=80000000 b=FFFFFFFF -> resp_data=0.
REQ-041 Bench SHALL cover REMU a=17 b=5 twice back-to-back -> first via divider (2), second a cache hit at N+1 with no div_start.
REQ-042 Bench SHALL cover flush in WAIT -> DRAIN, late div_done discarded, no resp_valid, next request served correctly.
REQ-043 Bench SHALL cover div_done withheld -> resp_valid and resp_err after TIMEOUT cycles, resp_data=0.
REQ-044 Bench SHALL cover rst=0 asserted in WAIT -> outputs 0 immediately; a repeat of the same op after release goes through the divider (cache invalid).

Source files
------------

// File: rtl/div_controller.sv
// Sequencing front-end between the execute stage and an iterative divider.
// Resolves special cases and repeated operands locally, stalls the pipe while the divider works.
`timescale 1ns/1ps

module div_controller #(
    parameter int BYPASS_EN = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        div_start,
    output logic [1:0]  div_opcode,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_done,
    input  logic [31:0] div_result
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam bit              BYPASS   = (BYPASS_EN != 0);
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    logic [1:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic          cache_valid;
    logic [1:0]    cache_op;
    logic [31:0]   cache_a;
    logic [31:0]   cache_b;
    logic [31:0]   cache_result;

    logic          accept;
    logic          special;
    logic [31:0]   special_result;
    logic          hit;

    // op[1] selects remainder, op[0] selects unsigned.
    always_comb begin
        special        = 1'b0;
        special_result = '0;
        if (req_b == 32'h0) begin
            special        = 1'b1;
            special_result = req_op[1] ? req_a : 32'hFFFF_FFFF;
        end else if (!req_op[0] && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
            special        = 1'b1;
            special_result = req_op[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    assign hit    = cache_valid && (cache_op == req_op) && (cache_a == req_a) && (cache_b == req_b);
    assign accept = (state == IDLE) && req_valid && !flush;

    // NOTE: stall is combinational on req_valid, so it is gated by rst to stay 0 while reset is held.
    assign stall = rst && (accept || (state == ISSUE) || (state == WAIT) ||
                           ((state == DRAIN) && req_valid));

    assign resp_valid = (state == RESP) && !flush;

    // Operands to the divider come straight from the latch, so they hold until the next accept.
    assign div_opcode = op_q;
    assign div_op1    = a_q;
    assign div_op2    = b_q;

    // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            div_start    <= 1'b0;
            cache_valid  <= 1'b0;
            cache_op     <= '0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_result <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= req_op;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        resp_err <= 1'b0;
                        if (BYPASS && special) begin
                            resp_data <= special_result;
                            state     <= RESP;
                        end else if (BYPASS && hit) begin
                            resp_data <= cache_result;
                            state     <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                // The start pulse is already on the wire here, so a flush still completes the handshake.
                ISSUE: begin
                    cnt   <= '0;
                    state <= flush ? DRAIN : WAIT;
                end

                WAIT: begin
                    if (div_done) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            resp_data    <= div_result;
                            resp_err     <= 1'b0;
                            cache_valid  <= 1'b1;
                            cache_op     <= op_q;
                            cache_a      <= a_q;
                            cache_b      <= b_q;
                            cache_result <= div_result;
                            state        <= RESP;
                        end
                    end else if (flush) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else if (cnt == CNT_LAST) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                DRAIN: begin
                    if (div_done || cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller: stimulus queues expected responses, a monitor
// pops and compares them whenever resp_valid is seen, and a small divider model answers div_start.
`timescale 1ns/1ps

module tb_div_controller;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        div_start;
    logic [1:0]  div_opcode;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_done = 1'b0;
    logic [31:0] div_result = '0;

    div_controller #(.BYPASS_EN(1), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .div_start  (div_start),
        .div_opcode (div_opcode),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       sb_q[$];
    logic [31:0] div_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_count = 0;
    int last_resp_cyc = -1;
    int start_count = 0;
    int last_start_cyc = -1;
    int div_delay = 1;
    bit div_hold = 1'b0;
    logic [1:0]  exp_opc = '0;
    logic [31:0] exp_op1 = '0;
    logic [31:0] exp_op2 = '0;
    bit stall_hist[1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall history, response scoreboard, divider launch checks.
    always @(negedge clk) begin
        resp_t e;
        if (cyc < 1024) stall_hist[cyc] = stall;
        if (resp_valid) begin
            resp_count++;
            last_resp_cyc = cyc;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: resp_valid with data %h err %0d, none expected", resp_data, resp_err);
            end else begin
                e = sb_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
        if (div_start) begin
            start_count++;
            last_start_cyc = cyc;
            check("div_opcode", 32'(div_opcode), 32'(exp_opc));
            check("div_op1", div_op1, exp_op1);
            check("div_op2", div_op2, exp_op2);
        end
    end

    // Divider model: answers each launch with the next queued result after div_delay cycles.
    initial begin
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (div_start && !div_hold && div_q.size() > 0) begin
                r = div_q.pop_front();
                repeat (div_delay) @(posedge clk);
                #1 div_done = 1'b1;
                div_result = r;
                @(posedge clk);
                #1 div_done = 1'b0;
                div_result = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op at the current cycle N and checks response, latency, launch and stall window.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input bit exp_err,
                          input bit via_div, input logic [31:0] div_res, input int lat);
        int n, s0, r0;
        bit ok;
        resp_t e;
        n  = cyc;
        s0 = start_count;
        r0 = resp_count;
        exp_opc = op;
        exp_op1 = a;
        exp_op2 = b;
        if (via_div && !div_hold) div_q.push_back(div_res);
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 200 && resp_count == r0; i++) tick();
        if (resp_count == r0) begin
            tests++;
            fails++;
            $display("FAIL %s_no_resp: no resp_valid within 200 cycles", name);
            sb_q.delete();
        end else begin
            check({name, "_latency"}, last_resp_cyc, n + lat);
        end
        check({name, "_starts"}, start_count, s0 + (via_div ? 1 : 0));
        if (via_div) check({name, "_start_cyc"}, last_start_cyc, n + 1);
        ok = 1'b1;
        for (int k = 0; k < lat; k++) if (!stall_hist[n + k]) ok = 1'b0;
        if (stall_hist[n + lat]) ok = 1'b0;
        check({name, "_stall_window"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0, r0;
        resp_t e;

        // Reset held with a request presented: every output must stay 0.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd100;
        req_b     = 32'd7;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_op1", div_op1, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Divider path, done one cycle after start.
        div_delay = 1;
        run_op("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, 32'd14, 3);

        // Special cases resolved without the divider.
        run_op("divu_b0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1);
        run_op("remu_b0", 2'b11, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 32'd0, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32'd0, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1);

        // Same op back-to-back: divider first, cache hit second.
        run_op("remu_first", 2'b11, 32'd17, 32'd5, 32'd2, 1'b0, 1'b1, 32'd2, 3);
        run_op("remu_hit", 2'b11, 32'd17, 32'd5, 32'd2, 1'b0, 1'b0, 32'd0, 1);

        // Flush in WAIT; late div_done must be swallowed by DRAIN.
        div_delay = 4;
        n  = cyc;
        s0 = start_count;
        exp_opc = 2'b00;
        exp_op1 = 32'd1000;
        exp_op2 = 32'd10;
        div_q.push_back(32'd100);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd1000;
        req_b     = 32'd10;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        div_delay = 1;
        r0 = resp_count;
        exp_opc = 2'b01;
        exp_op1 = 32'd81;
        exp_op2 = 32'd9;
        div_q.push_back(32'd9);
        e.data = 32'd9;
        e.err  = 1'b0;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd81;
        req_b     = 32'd9;
        @(negedge clk);
        check("drain_stall_req", 32'(stall), 32'd1);
        repeat (4) tick();
        req_valid = 1'b0;
        for (int i = 0; i < 50 && resp_count == r0; i++) tick();
        check("flush_next_resp_cyc", last_resp_cyc, n + 9);
        check("flush_next_start_cyc", last_start_cyc, n + 7);
        check("flush_starts", start_count, s0 + 2);
        repeat (3) tick();
        check("flush_resp_count", resp_count, r0 + 1);

        // Divider never answers: timeout response, nothing cached.
        div_hold = 1'b1;
        run_op("timeout", 2'b01, 32'd50, 32'd3, 32'd0, 1'b1, 1'b1, 32'd0, 2 + TIMEOUT);
        div_hold = 1'b0;
        run_op("after_timeout", 2'b01, 32'd50, 32'd3, 32'd16, 1'b0, 1'b1, 32'd16, 3);
        run_op("after_timeout_hit", 2'b01, 32'd50, 32'd3, 32'd16, 1'b0, 1'b0, 32'd0, 1);

        // Reset asserted while in WAIT.
        div_hold = 1'b1;
        r0 = resp_count;
        exp_opc = 2'b00;
        exp_op1 = 32'd100;
        exp_op2 = 32'd7;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd100;
        req_b     = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        check("wait_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_data", resp_data, 32'd0);
        check("midrst_resp_err", 32'(resp_err), 32'd0);
        check("midrst_div_start", 32'(div_start), 32'd0);
        check("midrst_div_opcode", 32'(div_opcode), 32'd0);
        check("midrst_div_op1", div_op1, 32'd0);
        check("midrst_div_op2", div_op2, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        div_hold = 1'b0;
        repeat (3) tick();
        check("midrst_no_resp", resp_count, r0);
        run_op("post_rst_cached_op", 2'b01, 32'd50, 32'd3, 32'd16, 1'b0, 1'b1, 32'd16, 3);
        run_op("post_rst_repeat", 2'b00, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, 32'd14, 3);

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
